text_source: RTL and testbench

- Transmit-side counterpart of the received-text sink.
- Reads a stored text message byte by byte from an external synchronous single-port memory (ROM/RAM read port).
- Presents each byte on a valid/ready byte stream to the downstream transmit chain (framer/modulator).
- Covers addresses 0..END_ADDRESS inclusive, then reports completion; it is the mirror of the sink, which fills addresses 0..end_address.

---
 rtl/text_source.sv | 144 ++++++++++++++
 tb/tb_text_source.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_source.sv
// ---------------------------------------------------------------------------
// text_source
//
// Transmit-side message reader. Walks a synchronous read-only memory from
// address 0 to END_ADDRESS, waits out the memory read latency for each
// address, and offers every byte on a valid/ready byte stream to the
// transmit chain. A one-cycle done pulse follows acceptance of the last byte.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset
//   start        one-cycle request to send the whole message (idle only)
//   abort        synchronous cancel, returns to IDLE without done
//   mem_address  registered memory read address
//   mem_q        memory read data, valid ROM_LATENCY cycles after address
//   data_out     registered byte offered downstream
//   data_valid   data_out holds a byte awaiting acceptance
//   data_ready   downstream accepts data_out on this edge
//   busy         high from start acceptance until return to IDLE
//   done         one-cycle pulse after the last byte is accepted
// ---------------------------------------------------------------------------
module text_source #(
  parameter int END_ADDRESS = 10,
  parameter int ADDR_W      = 8,
  parameter int ROM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] mem_address,
  input  logic [7:0]        mem_q,
  output logic [7:0]        data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              busy,
  output logic              done
);

  localparam int DATA_W = 8;
  localparam int CNT_W  = 3;

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(END_ADDRESS);
  // The counter reaches ROM_LATENCY on the edge where mem_q has been valid
  // for a full cycle, i.e. ROM_LATENCY+1 edges after the address was set.
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(ROM_LATENCY);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    PRESENT = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  wait_cnt;
  logic              handshake;

  assign handshake = data_valid & data_ready;

  // Address advance that can never step past the last message byte.
  function automatic logic [ADDR_W-1:0] sat_inc_addr(input logic [ADDR_W-1:0] a);
    if (a >= ADDR_LAST)
      return ADDR_LAST;
    return a + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      mem_address <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      wait_cnt    <= '0;
    end else if (abort && (state != IDLE)) begin
      // Cancel: data_out deliberately keeps the last byte presented.
      state       <= IDLE;
      mem_address <= '0;
      data_valid  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          data_valid <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
          // abort in the same cycle suppresses the start request
          if (start && !abort) begin
            mem_address <= '0;
            wait_cnt    <= '0;
            busy        <= 1'b1;
            state       <= READ;
          end
        end

        // Stage boundary: address issued, waiting for memory data
        READ: begin
          if (wait_cnt == CNT_LAST) begin
            data_out   <= mem_q[DATA_W-1:0];
            data_valid <= 1'b1;
            wait_cnt   <= '0;
            state      <= PRESENT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        // Stage boundary: byte held on the stream until accepted
        PRESENT: begin
          if (handshake) begin
            data_valid <= 1'b0;
            if (mem_address == ADDR_LAST) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              mem_address <= sat_inc_addr(mem_address);
              wait_cnt    <= '0;
              state       <= READ;
            end
          end
        end

        DONE: begin
          done        <= 1'b0;
          busy        <= 1'b0;
          mem_address <= '0;
          state       <= IDLE;
        end

        default: begin
          state      <= IDLE;
          data_valid <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_text_source.sv
module tb_text_source;

  localparam logic [7:0] MSG [0:10] = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h20,
                                        8'h57, 8'h4F, 8'h52, 8'h4C, 8'h44};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // Instance A: ROM_LATENCY = 1
  logic       start_a, abort_a, ready_a;
  logic [7:0] addr_a, q_a, data_a;
  logic       valid_a, busy_a, done_a;

  // Instance B: ROM_LATENCY = 3
  logic       start_b, abort_b, ready_b;
  logic [7:0] addr_b, q_b, data_b;
  logic       valid_b, busy_b, done_b;
  logic [7:0] qb1, qb2;

  int n_vec = 0;
  int n_bad = 0;

  logic [7:0] rx_q [$];
  int         done_cnt = 0;

  text_source #(.END_ADDRESS(10), .ADDR_W(8), .ROM_LATENCY(1)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .abort(abort_a),
    .mem_address(addr_a), .mem_q(q_a), .data_out(data_a),
    .data_valid(valid_a), .data_ready(ready_a), .busy(busy_a), .done(done_a)
  );

  text_source #(.END_ADDRESS(10), .ADDR_W(8), .ROM_LATENCY(3)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .abort(abort_b),
    .mem_address(addr_b), .mem_q(q_b), .data_out(data_b),
    .data_valid(valid_b), .data_ready(ready_b), .busy(busy_b), .done(done_b)
  );

  function automatic logic [7:0] rom_rd(input logic [7:0] a);
    if (a <= 8'd10) return MSG[int'(a)];
    return 8'h00;
  endfunction

  // Memory models: one-cycle and three-cycle registered read
  always @(posedge clk) q_a <= rom_rd(addr_a);
  always @(posedge clk) begin
    qb1 <= rom_rd(addr_b);
    qb2 <= qb1;
    q_b <= qb2;
  end

  // Stream monitor for instance A: a byte is taken on the coming edge when
  // valid and ready are both high after the negedge drive settles.
  always begin
    @(negedge clk);
    #1;
    if (valid_a === 1'b1 && ready_a === 1'b1) rx_q.push_back(data_a);
    if (done_a === 1'b1) done_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic pulse_start_a();
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
  endtask

  task automatic wait_rx(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (rx_q.size() >= n) ok = 1'b1;
    end
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (done_a === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++; if (addr_a !== 8'h00) begin n_bad++; $display("FAIL reset_addr: got %h want 00", addr_a); end
    n_vec++; if (data_a !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h want 00", data_a); end
    n_vec++; if (valid_a !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", valid_a); end
    n_vec++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy_a); end
    n_vec++; if (done_a !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done_a); end
    n_vec++; if (busy_b !== 1'b0) begin n_bad++; $display("FAIL reset_busy_b: got %b want 0", busy_b); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_stream();
    bit exp_v;
    int idx;
    rx_q.delete(); done_cnt = 0;
    ready_a = 1'b1;
    pulse_start_a();
    for (int c = 0; c <= 35; c++) begin
      if (c > 0) @(negedge clk);
      exp_v = (c >= 2 && c <= 32 && ((c - 2) % 3) == 0);
      idx = (c - 2) / 3;
      n_vec++; if (valid_a !== exp_v) begin n_bad++; $display("FAIL stream_valid c=%0d: got %b want %b", c, valid_a, exp_v); end
      if (exp_v) begin
        n_vec++; if (data_a !== MSG[idx]) begin n_bad++; $display("FAIL stream_data c=%0d: got %h want %h", c, data_a, MSG[idx]); end
        n_vec++; if (addr_a !== 8'(idx)) begin n_bad++; $display("FAIL stream_addr c=%0d: got %0d want %0d", c, addr_a, idx); end
      end
      n_vec++; if (done_a !== (c == 33)) begin n_bad++; $display("FAIL stream_done c=%0d: got %b want %b", c, done_a, (c == 33)); end
      n_vec++; if (busy_a !== (c <= 33)) begin n_bad++; $display("FAIL stream_busy c=%0d: got %b want %b", c, busy_a, (c <= 33)); end
    end
    n_vec++; if (rx_q.size() != 11) begin n_bad++; $display("FAIL stream_count: got %0d want 11", rx_q.size()); end
    n_vec++; if (addr_a !== 8'h00) begin n_bad++; $display("FAIL stream_addr_idle: got %0d want 0", addr_a); end
  endtask

  task automatic test_backpressure();
    bit pv, pr, seen;
    logic [7:0] pd;
    int stall;
    rx_q.delete(); done_cnt = 0;
    ready_a = 1'b0;
    pv = 1'b0; pr = 1'b0; pd = 8'h00; stall = 2; seen = 1'b0;
    pulse_start_a();
    for (int i = 0; i < 600 && !seen; i++) begin
      @(negedge clk);
      if (pv && !pr) begin
        n_vec++;
        if (valid_a !== 1'b1 || data_a !== pd) begin
          n_bad++; $display("FAIL bp_hold: got valid=%b data=%h want valid=1 data=%h", valid_a, data_a, pd);
        end
      end
      pv = valid_a; pd = data_a;
      if (stall == 0) begin ready_a = 1'b1; stall = $urandom_range(0, 5); end
      else begin ready_a = 1'b0; stall--; end
      pr = ready_a;
      if (done_a === 1'b1) seen = 1'b1;
    end
    n_vec++; if (!seen) begin n_bad++; $display("FAIL bp_timeout: got no done want done"); end
    @(negedge clk); ready_a = 1'b1;
    n_vec++; if (rx_q.size() != 11) begin n_bad++; $display("FAIL bp_count: got %0d want 11", rx_q.size()); end
    for (int i = 0; i < 11 && i < rx_q.size(); i++) begin
      n_vec++; if (rx_q[i] !== MSG[i]) begin n_bad++; $display("FAIL bp_byte%0d: got %h want %h", i, rx_q[i], MSG[i]); end
    end
    n_vec++; if (done_cnt != 1) begin n_bad++; $display("FAIL bp_done_count: got %0d want 1", done_cnt); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    rx_q.delete(); done_cnt = 0;
    ready_a = 1'b1;
    pulse_start_a();
    wait_rx(4, ok);
    n_vec++; if (!ok) begin n_bad++; $display("FAIL rm_wait4: got timeout want 4 bytes"); end
    #3 reset = 1'b1;
    #1;
    n_vec++; if (addr_a !== 8'h00) begin n_bad++; $display("FAIL rm_addr: got %h want 00", addr_a); end
    n_vec++; if (data_a !== 8'h00) begin n_bad++; $display("FAIL rm_data: got %h want 00", data_a); end
    n_vec++; if (valid_a !== 1'b0) begin n_bad++; $display("FAIL rm_valid: got %b want 0", valid_a); end
    n_vec++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL rm_busy: got %b want 0", busy_a); end
    n_vec++; if (done_a !== 1'b0) begin n_bad++; $display("FAIL rm_done: got %b want 0", done_a); end
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    rx_q.delete(); done_cnt = 0;
    pulse_start_a();
    wait_done(ok);
    n_vec++; if (!ok) begin n_bad++; $display("FAIL rm_restart_done: got timeout want done"); end
    @(negedge clk);
    n_vec++; if (rx_q.size() != 11) begin n_bad++; $display("FAIL rm_count: got %0d want 11", rx_q.size()); end
    if (rx_q.size() == 11) begin
      n_vec++; if (rx_q[0] !== 8'h48) begin n_bad++; $display("FAIL rm_first: got %h want 48", rx_q[0]); end
      n_vec++; if (rx_q[10] !== 8'h44) begin n_bad++; $display("FAIL rm_last: got %h want 44", rx_q[10]); end
    end
    n_vec++; if (done_cnt != 1) begin n_bad++; $display("FAIL rm_done_count: got %0d want 1", done_cnt); end
  endtask

  task automatic test_restart_ignored();
    bit ok;
    rx_q.delete(); done_cnt = 0;
    ready_a = 1'b1;
    pulse_start_a();
    wait_rx(5, ok);
    n_vec++; if (!ok) begin n_bad++; $display("FAIL ri_wait5: got timeout want 5 bytes"); end
    start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    wait_done(ok);
    n_vec++; if (!ok) begin n_bad++; $display("FAIL ri_done: got timeout want done"); end
    repeat (8) @(negedge clk);
    n_vec++; if (rx_q.size() != 11) begin n_bad++; $display("FAIL ri_count: got %0d want 11", rx_q.size()); end
    for (int i = 0; i < 11 && i < rx_q.size(); i++) begin
      n_vec++; if (rx_q[i] !== MSG[i]) begin n_bad++; $display("FAIL ri_byte%0d: got %h want %h", i, rx_q[i], MSG[i]); end
    end
    n_vec++; if (done_cnt != 1) begin n_bad++; $display("FAIL ri_done_count: got %0d want 1", done_cnt); end
    n_vec++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL ri_busy_after: got %b want 0", busy_a); end
  endtask

  task automatic test_abort();
    bit ok;
    rx_q.delete(); done_cnt = 0;
    ready_a = 1'b1;
    pulse_start_a();
    wait_rx(6, ok);
    n_vec++; if (!ok) begin n_bad++; $display("FAIL ab_wait6: got timeout want 6 bytes"); end
    abort_a = 1'b1;
    @(negedge clk); abort_a = 1'b0;
    n_vec++; if (valid_a !== 1'b0) begin n_bad++; $display("FAIL ab_valid: got %b want 0", valid_a); end
    n_vec++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL ab_busy: got %b want 0", busy_a); end
    n_vec++; if (done_a !== 1'b0) begin n_bad++; $display("FAIL ab_done: got %b want 0", done_a); end
    n_vec++; if (addr_a !== 8'h00) begin n_bad++; $display("FAIL ab_addr: got %0d want 0", addr_a); end
    n_vec++; if (data_a !== 8'h20) begin n_bad++; $display("FAIL ab_data_kept: got %h want 20", data_a); end
    repeat (6) @(negedge clk);
    n_vec++; if (rx_q.size() != 6) begin n_bad++; $display("FAIL ab_count: got %0d want 6", rx_q.size()); end
    n_vec++; if (done_cnt != 0) begin n_bad++; $display("FAIL ab_no_done: got %0d want 0", done_cnt); end
    // start and abort together while idle
    start_a = 1'b1; abort_a = 1'b1;
    @(negedge clk); start_a = 1'b0; abort_a = 1'b0;
    n_vec++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL sa_busy: got %b want 0", busy_a); end
    repeat (4) @(negedge clk);
    n_vec++; if (valid_a !== 1'b0) begin n_bad++; $display("FAIL sa_valid: got %b want 0", valid_a); end
    n_vec++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL sa_busy_late: got %b want 0", busy_a); end
  endtask

  task automatic test_latency3();
    bit exp_v;
    int idx;
    ready_b = 1'b1;
    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    for (int c = 0; c <= 57; c++) begin
      if (c > 0) @(negedge clk);
      exp_v = (c >= 4 && c <= 54 && ((c - 4) % 5) == 0);
      idx = (c - 4) / 5;
      n_vec++; if (valid_b !== exp_v) begin n_bad++; $display("FAIL l3_valid c=%0d: got %b want %b", c, valid_b, exp_v); end
      if (exp_v) begin
        n_vec++; if (data_b !== MSG[idx]) begin n_bad++; $display("FAIL l3_data c=%0d: got %h want %h", c, data_b, MSG[idx]); end
      end
      n_vec++; if (done_b !== (c == 55)) begin n_bad++; $display("FAIL l3_done c=%0d: got %b want %b", c, done_b, (c == 55)); end
      n_vec++; if (busy_b !== (c <= 55)) begin n_bad++; $display("FAIL l3_busy c=%0d: got %b want %b", c, busy_b, (c <= 55)); end
    end
  endtask

  initial begin
    reset = 1'b1;
    start_a = 1'b0; abort_a = 1'b0; ready_a = 1'b0;
    start_b = 1'b0; abort_b = 1'b0; ready_b = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_reset_mid();
    test_restart_ignored();
    test_abort();
    test_latency3();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
